// File: rtl/sprite_pkg.sv
// Shared types and constants for the coin sprite reader.
package sprite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SPIN,
    ST_POP,
    ST_DONE
  } state_t;

  localparam logic [23:0] TRANSPARENT_KEY = 24'h800080;
  localparam int unsigned DEF_SPRITE_W    = 20;
  localparam int unsigned DEF_SPRITE_H    = 20;

endpackage

// File: rtl/sprite_addr_gen.sv
// Sprite bounding-box test and ROM address arithmetic for the current scan pixel.
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int unsigned SPRITE_W = DEF_SPRITE_W,
  parameter int unsigned SPRITE_H = DEF_SPRITE_H
) (
  input  logic [9:0] i_coin_x,
  input  logic [9:0] i_eff_y,
  input  logic [9:0] i_draw_x,
  input  logic [9:0] i_draw_y,
  output logic       o_inside,
  output logic [8:0] o_addr
);

  logic [10:0] w_x0, w_x1, w_y0, w_y1, w_px, w_py;
  logic [8:0]  w_dx, w_dy;

  // 11-bit bounds so a sprite hanging off the right/bottom edge never wraps
  assign w_x0 = {1'b0, i_coin_x};
  assign w_x1 = w_x0 + 11'(SPRITE_W);
  assign w_y0 = {1'b0, i_eff_y};
  assign w_y1 = w_y0 + 11'(SPRITE_H);
  assign w_px = {1'b0, i_draw_x};
  assign w_py = {1'b0, i_draw_y};

  assign o_inside = (w_px >= w_x0) && (w_px < w_x1) && (w_py >= w_y0) && (w_py < w_y1);

  assign w_dx = 9'(i_draw_x - i_coin_x);
  assign w_dy = 9'(i_draw_y - i_eff_y);

  assign o_addr = o_inside ? 9'(w_dy * 9'(SPRITE_W) + w_dx) : '0;

endmodule

// File: rtl/coin_sprite_reader.sv
// Animated coin sprite: spin/pop FSM, frame sequencing and a two-stage ROM read pipeline.
module coin_sprite_reader
  import sprite_pkg::*;
#(
  parameter int unsigned SPRITE_W   = DEF_SPRITE_W,
  parameter int unsigned SPRITE_H   = DEF_SPRITE_H,
  parameter int unsigned NUM_FRAMES = 4,
  parameter int unsigned FRAME_HOLD = 6,
  parameter int unsigned POP_LEN    = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic        coin_active,
  input  logic        collect,
  input  logic [9:0]  coin_x,
  input  logic [9:0]  coin_y,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic [23:0] rom_color,
  output logic [8:0]  read_address,
  output logic [1:0]  frame_sel,
  output logic        pixel_on,
  output logic [23:0] pixel_color,
  output logic        busy
);

  state_t      r_state, w_state_nxt;
  logic        r_frame_clk;
  logic [7:0]  r_hold;
  logic [1:0]  r_frame_sel;
  logic [9:0]  r_pop_ofs;
  logic [8:0]  r_read_address;
  logic        r_inside_q;
  logic        r_pixel_on;
  logic [23:0] r_pixel_color;

  logic        w_tick, w_animate, w_pop_last, w_inside;
  logic [1:0]  w_frame_nxt;
  logic [9:0]  w_eff_y;
  logic [8:0]  w_addr;

  assign w_tick      = frame_clk & ~r_frame_clk;
  assign w_animate   = (r_state == ST_SPIN) || (r_state == ST_POP);
  assign w_pop_last  = (r_pop_ofs == 10'(POP_LEN - 1));
  assign w_frame_nxt = (r_frame_sel == 2'(NUM_FRAMES - 1)) ? '0 : r_frame_sel + 2'd1;
  assign w_eff_y     = (coin_y >= r_pop_ofs) ? coin_y - r_pop_ofs : '0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (coin_active) w_state_nxt = ST_SPIN;
      ST_SPIN: begin
        if (!coin_active)  w_state_nxt = ST_IDLE;
        else if (collect)  w_state_nxt = ST_POP;
      end
      ST_POP: begin
        if (!coin_active)                w_state_nxt = ST_IDLE;
        else if (w_tick && w_pop_last)   w_state_nxt = ST_DONE;
      end
      ST_DONE: if (!coin_active) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Counters act on the current state, so a tick coinciding with collect still advances the frame
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= ST_IDLE;
      r_frame_clk <= 1'b0;
      r_hold      <= '0;
      r_frame_sel <= '0;
      r_pop_ofs   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_clk <= frame_clk;
      if (r_state == ST_IDLE) begin
        r_hold      <= '0;
        r_frame_sel <= '0;
        r_pop_ofs   <= '0;
      end else begin
        if (w_animate && w_tick) begin
          if (r_hold == 8'(FRAME_HOLD - 1)) begin
            r_hold      <= '0;
            r_frame_sel <= w_frame_nxt;
          end else begin
            r_hold <= r_hold + 8'd1;
          end
        end
        if ((r_state == ST_POP) && w_tick) r_pop_ofs <= r_pop_ofs + 10'd1;
      end
    end
  end

  sprite_addr_gen #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_addr_gen (
    .i_coin_x (coin_x),
    .i_eff_y  (w_eff_y),
    .i_draw_x (draw_x),
    .i_draw_y (draw_y),
    .o_inside (w_inside),
    .o_addr   (w_addr)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_read_address <= '0;
      r_inside_q     <= 1'b0;
      r_pixel_on     <= 1'b0;
      r_pixel_color  <= '0;
    end else begin
      r_read_address <= w_addr;
      r_inside_q     <= w_inside;
      r_pixel_color  <= rom_color;
      r_pixel_on     <= r_inside_q && w_animate && (rom_color != TRANSPARENT_KEY);
    end
  end

  assign read_address = r_read_address;
  assign frame_sel    = r_frame_sel;
  assign pixel_on     = r_pixel_on;
  assign pixel_color  = r_pixel_color;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_coin_sprite_reader.sv
// Randomized self-checking bench for coin_sprite_reader against a behavioural sprite model.
module tb_coin_sprite_reader;

  localparam logic [23:0] KEY = 24'h800080;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_clk = 1'b0;
  logic        coin_active = 1'b0;
  logic        collect = 1'b0;
  logic [9:0]  coin_x = 10'd100;
  logic [9:0]  coin_y = 10'd50;
  logic [9:0]  draw_x = '0;
  logic [9:0]  draw_y = '0;
  logic [23:0] rom_color;
  logic [8:0]  read_address;
  logic [1:0]  frame_sel;
  logic        pixel_on;
  logic [23:0] pixel_color;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode 0 idle, 1 spin, 2 pop, 3 done; ticks counted while animating
  int m_mode  = 0;
  int m_ticks = 0;
  int m_pop   = 0;

  logic [23:0] rom_mem [0:3][0:399];
  logic [8:0]  got_addr;
  logic        got_on;
  logic [23:0] got_col;

  assign rom_color = (read_address < 9'd400) ? rom_mem[frame_sel][read_address] : 24'h0;

  always #5 Clk = ~Clk;

  coin_sprite_reader #(
    .SPRITE_W   (20),
    .SPRITE_H   (20),
    .NUM_FRAMES (4),
    .FRAME_HOLD (6),
    .POP_LEN    (16)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_clk    (frame_clk),
    .coin_active  (coin_active),
    .collect      (collect),
    .coin_x       (coin_x),
    .coin_y       (coin_y),
    .draw_x       (draw_x),
    .draw_y       (draw_y),
    .rom_color    (rom_color),
    .read_address (read_address),
    .frame_sel    (frame_sel),
    .pixel_on     (pixel_on),
    .pixel_color  (pixel_color),
    .busy         (busy)
  );

  function automatic int model_eff();
    int cy = int'(coin_y);
    return (cy >= m_pop) ? cy - m_pop : 0;
  endfunction

  function automatic int model_frame();
    return (m_ticks / 6) % 4;
  endfunction

  function automatic bit model_inside(int x, int y);
    int cx = int'(coin_x);
    int e  = model_eff();
    return (x >= cx) && (x < cx + 20) && (y >= e) && (y < e + 20);
  endfunction

  function automatic int model_addr(int x, int y);
    return model_inside(x, y) ? (y - model_eff()) * 20 + (x - int'(coin_x)) : 0;
  endfunction

  function automatic bit model_on(int x, int y);
    return model_inside(x, y) && (m_mode == 1 || m_mode == 2) &&
           (rom_mem[model_frame()][model_addr(x, y)] != KEY);
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_tick();
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    step();
    if (m_mode == 1 || m_mode == 2) m_ticks++;
    if (m_mode == 2) begin
      m_pop++;
      if (m_pop == 16) m_mode = 3;
    end
  endtask

  task automatic go_idle();
    coin_active = 1'b0;
    step();
    step();
    m_mode = 0; m_ticks = 0; m_pop = 0;
  endtask

  task automatic go_spin();
    coin_active = 1'b1;
    step();
    m_mode = 1; m_ticks = 0; m_pop = 0;
  endtask

  task automatic do_collect();
    collect = 1'b1;
    step();
    collect = 1'b0;
    if (m_mode == 1) m_mode = 2;
  endtask

  task automatic probe(input int x, input int y);
    draw_x = 10'(x);
    draw_y = 10'(y);
    step();
    got_addr = read_address;
    step();
    got_on  = pixel_on;
    got_col = pixel_color;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    coin_active = 1'b1;
    step(); step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (frame_sel !== 2'd0) begin errors++; $display("FAIL reset_frame got %0d want 0", frame_sel); end
    checks++; if (read_address !== 9'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", read_address); end
    checks++; if (pixel_on !== 1'b0) begin errors++; $display("FAIL reset_on got %0b want 0", pixel_on); end
    checks++; if (pixel_color !== 24'h0) begin errors++; $display("FAIL reset_color got %h want 000000", pixel_color); end
    coin_active = 1'b0;
    Reset_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b want 0", busy); end
    m_mode = 0; m_ticks = 0; m_pop = 0;
  endtask

  task automatic test_address();
    int px [8] = '{105, 119, 120, 99, 100, 119, 100, 100};
    int py [8] = '{52,  69,  69,  50, 50,  50,  70,  69};
    int x, y;
    coin_x = 10'd100; coin_y = 10'd50;
    go_spin();
    for (int unsigned i = 0; i < 8; i++) begin
      probe(px[i], py[i]);
      checks++; if (got_addr !== 9'(model_addr(px[i], py[i]))) begin errors++;
        $display("FAIL addr_table(%0d,%0d) got %0d want %0d", px[i], py[i], got_addr, model_addr(px[i], py[i])); end
      checks++; if (got_on !== model_on(px[i], py[i])) begin errors++;
        $display("FAIL on_table(%0d,%0d) got %0b want %0b", px[i], py[i], got_on, model_on(px[i], py[i])); end
    end
    for (int unsigned i = 0; i < 40; i++) begin
      coin_x = 10'($urandom_range(0, 1023));
      coin_y = 10'($urandom_range(0, 1023));
      x = int'(coin_x) + int'($urandom_range(0, 25)) - 3;
      y = int'(coin_y) + int'($urandom_range(0, 25)) - 3;
      if (x < 0) x = 0;
      if (x > 1023) x = 1023;
      if (y < 0) y = 0;
      if (y > 1023) y = 1023;
      probe(x, y);
      checks++; if (got_addr !== 9'(model_addr(x, y))) begin errors++;
        $display("FAIL addr_rand c=(%0d,%0d) d=(%0d,%0d) got %0d want %0d", coin_x, coin_y, x, y, got_addr, model_addr(x, y)); end
      checks++; if (got_on !== model_on(x, y)) begin errors++;
        $display("FAIL on_rand d=(%0d,%0d) got %0b want %0b", x, y, got_on, model_on(x, y)); end
      checks++; if (got_col !== rom_mem[model_frame()][model_addr(x, y)]) begin errors++;
        $display("FAIL color_rand d=(%0d,%0d) got %h want %h", x, y, got_col, rom_mem[model_frame()][model_addr(x, y)]); end
    end
    coin_x = 10'd100; coin_y = 10'd50;
  endtask

  task automatic test_transparency();
    rom_mem[model_frame()][45] = KEY;
    probe(105, 52);
    checks++; if (got_on !== 1'b0) begin errors++; $display("FAIL key_on got %0b want 0", got_on); end
    rom_mem[model_frame()][45] = 24'hF83800;
    probe(105, 52);
    checks++; if (got_on !== 1'b1) begin errors++; $display("FAIL opaque_on got %0b want 1", got_on); end
    checks++; if (got_col !== 24'hF83800) begin errors++; $display("FAIL opaque_color got %h want F83800", got_col); end
    go_idle();
    rom_mem[0][45] = 24'hF83800;
    probe(105, 52);
    checks++; if (got_addr !== 9'd45) begin errors++; $display("FAIL idle_addr got %0d want 45", got_addr); end
    checks++; if (got_on !== 1'b0) begin errors++; $display("FAIL idle_on got %0b want 0", got_on); end
  endtask

  task automatic test_frame_anim();
    go_idle();
    go_spin();
    checks++; if (frame_sel !== 2'd0) begin errors++; $display("FAIL frame_start got %0d want 0", frame_sel); end
    for (int unsigned i = 0; i < 24; i++) begin
      do_tick();
      step();
      checks++; if (frame_sel !== 2'(model_frame())) begin errors++;
        $display("FAIL frame_tick%0d got %0d want %0d", i + 1, frame_sel, model_frame()); end
    end
  endtask

  task automatic test_pop();
    go_idle();
    coin_x = 10'd100; coin_y = 10'd10;
    go_spin();
    do_collect();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pop_busy got %0b want 1", busy); end
    for (int unsigned i = 0; i < 20; i++) begin
      do_tick();
      probe(105, 12);
      checks++; if (got_addr !== 9'(model_addr(105, 12))) begin errors++;
        $display("FAIL pop_addr t%0d got %0d want %0d", i + 1, got_addr, model_addr(105, 12)); end
      checks++; if (got_on !== model_on(105, 12)) begin errors++;
        $display("FAIL pop_on t%0d got %0b want %0b", i + 1, got_on, model_on(105, 12)); end
    end
    do_collect();
    probe(105, 12);
    checks++; if (got_on !== 1'b0) begin errors++; $display("FAIL done_on got %0b want 0", got_on); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL done_busy got %0b want 1", busy); end
    coin_active = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_exit got %0b want 0", busy); end
    go_idle();
    coin_y = 10'd50;
  endtask

  task automatic test_back_to_back();
    go_spin();
    for (int unsigned i = 0; i < 5; i++) do_tick();
    frame_clk = 1'b1; collect = 1'b1;
    step();
    frame_clk = 1'b0; collect = 1'b0;
    step();
    m_ticks++; m_mode = 2;
    checks++; if (frame_sel !== 2'd1) begin errors++; $display("FAIL b2b_frame got %0d want 1", frame_sel); end
    probe(105, 50);
    checks++; if (got_addr !== 9'(model_addr(105, 50))) begin errors++;
      $display("FAIL b2b_addr0 got %0d want %0d", got_addr, model_addr(105, 50)); end
    do_tick();
    probe(105, 50);
    checks++; if (got_addr !== 9'(model_addr(105, 50))) begin errors++;
      $display("FAIL b2b_addr1 got %0d want %0d", got_addr, model_addr(105, 50)); end
    coin_active = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b want 0", busy); end
    step();
    checks++; if (frame_sel !== 2'd0) begin errors++; $display("FAIL abort_frame got %0d want 0", frame_sel); end
    m_mode = 0; m_ticks = 0; m_pop = 0;
    collect = 1'b1;
    step();
    collect = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_collect got %0b want 0", busy); end
  endtask

  task automatic test_reset_mid_pop();
    go_idle();
    coin_x = 10'd100; coin_y = 10'd50;
    rom_mem[0][205] = 24'h123456;
    go_spin();
    do_collect();
    for (int unsigned i = 0; i < 3; i++) do_tick();
    probe(105, 57);
    Reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %0b want 0", busy); end
    checks++; if (read_address !== 9'd0) begin errors++; $display("FAIL arst_addr got %0d want 0", read_address); end
    checks++; if (pixel_on !== 1'b0) begin errors++; $display("FAIL arst_on got %0b want 0", pixel_on); end
    checks++; if (pixel_color !== 24'h0) begin errors++; $display("FAIL arst_color got %h want 000000", pixel_color); end
    checks++; if (frame_sel !== 2'd0) begin errors++; $display("FAIL arst_frame got %0d want 0", frame_sel); end
    step();
    Reset_n = 1'b1;
    step();
    m_mode = 1; m_ticks = 0; m_pop = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rel_busy got %0b want 1", busy); end
    checks++; if (frame_sel !== 2'd0) begin errors++; $display("FAIL rel_frame got %0d want 0", frame_sel); end
    probe(105, 60);
    checks++; if (got_addr !== 9'd205) begin errors++; $display("FAIL rel_addr got %0d want 205", got_addr); end
    checks++; if (got_on !== 1'b1) begin errors++; $display("FAIL rel_on got %0b want 1", got_on); end
  endtask

  initial begin
    for (int unsigned f = 0; f < 4; f++)
      for (int unsigned a = 0; a < 400; a++)
        rom_mem[f][a] = ($urandom_range(0, 3) == 0) ? KEY : (24'($urandom) | 24'h000001) & 24'hFFFF7F;
    test_reset();
    test_address();
    test_transparency();
    test_frame_anim();
    test_pop();
    test_back_to_back();
    test_reset_mid_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
